button_debounce: RTL and testbench

Debounces the synchronized, active-low push-button level from the two-flop button synchronizer and turns it into a clean pressed level plus single-cycle press/release strobes. With auto-repeat compiled in, it also emits repeat strobes while a button is held. It sits between the button synchronizer and the DDS control logic (frequency/waveform step FSM). One instance per button.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/button_debounce_if.sv | 26 ++
 rtl/btn_repeat_timer.sv | 46 ++++
 rtl/button_debounce.sv | 124 ++++++++++++
 tb/tb_button_debounce.sv | 131 +++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM states, 50 MHz
// timing defaults and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btnState_e;

  // 10 ms debounce, 0.5 s to first repeat, 10 repeats per second at 50 MHz.
  localparam int unsigned DefDebounceCycles = 500000;
  localparam int unsigned DefRepeatDelay    = 25000000;
  localparam int unsigned DefRepeatPeriod   = 5000000;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button signal bundle: synchronized raw level in, debounced level and strobes out.
interface button_debounce_if;
  logic iIntBtn;
  logic oBtnLevel;
  logic oBtnPress;
  logic oBtnRelease;
  logic oBtnRepeat;

  // Upstream synchronizer / consumer side.
  modport master (
    output iIntBtn,
    input  oBtnLevel,
    input  oBtnPress,
    input  oBtnRelease,
    input  oBtnRepeat
  );

  // Debouncer side.
  modport slave (
    input  iIntBtn,
    output oBtnLevel,
    output oBtnPress,
    output oBtnRelease,
    output oBtnRepeat
  );
endinterface

// File: rtl/btn_repeat_timer.sv
// Auto-repeat timer: after a load, pulses once REPEAT_DELAY enabled cycles have
// elapsed, then every REPEAT_PERIOD enabled cycles. Used when BTN_AUTOREPEAT_EN is defined.
module btn_repeat_timer import btn_pkg::*; #(
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input  logic CLK,
  input  logic RESET,
  input  logic iEnable,
  input  logic iLoad,
  input  logic iClear,
  output logic oBtnRepeat
);

  localparam int unsigned TmrW = cntWidth(maxU(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TmrW-1:0] DelayLoad  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLoad = TmrW'(REPEAT_PERIOD - 1);

  logic [TmrW-1:0] tmrQ;
  logic            pulseQ;

  // Down-counter; reaching zero while enabled fires a pulse and reloads the period.
  always_ff @(posedge CLK) begin
    if (RESET || iClear) begin
      tmrQ   <= '0;
      pulseQ <= 1'b0;
    end else if (iLoad) begin
      tmrQ   <= DelayLoad;
      pulseQ <= 1'b0;
    end else if (iEnable) begin
      if (tmrQ == '0) begin
        tmrQ   <= PeriodLoad;
        pulseQ <= 1'b1;
      end else begin
        tmrQ   <= tmrQ - 1'b1;
        pulseQ <= 1'b0;
      end
    end else begin
      // Paused: keep the remaining time so a debounced glitch does not restart it.
      pulseQ <= 1'b0;
    end
  end

  assign oBtnRepeat = pulseQ;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: turns the synchronized active-low button level into a
// clean pressed level and one-cycle press/release strobes.
// Optional feature macro: BTN_AUTOREPEAT_EN adds auto-repeat strobes while held.
module button_debounce import btn_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input logic               CLK,
  input logic               RESET,
  button_debounce_if.slave  btn
);

  if (DEBOUNCE_CYCLES < 2) begin : genBadDebounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : genBadRepeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam int unsigned     CntW    = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  btnState_e       stateQ;
  logic [CntW-1:0] countQ;
  logic            levelQ;
  logic            pressQ;
  logic            releaseQ;
  logic            repeatPulse;

  // Debounce FSM; the counter is cleared on every state change so it never wraps.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateQ   <= IDLE;
      countQ   <= '0;
      levelQ   <= 1'b0;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
    end else begin
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (!btn.iIntBtn) begin
            stateQ <= PRESS_WAIT;
            countQ <= CntOne;
          end else begin
            countQ <= '0;
          end
        end
        PRESS_WAIT: begin
          if (btn.iIntBtn) begin
            stateQ <= IDLE;
            countQ <= '0;
          end else if (countQ == CntLast) begin
            stateQ <= PRESSED;
            countQ <= '0;
            levelQ <= 1'b1;
            pressQ <= 1'b1;
          end else begin
            countQ <= countQ + 1'b1;
          end
        end
        PRESSED: begin
          if (btn.iIntBtn) begin
            stateQ <= RELEASE_WAIT;
            countQ <= CntOne;
          end else begin
            countQ <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!btn.iIntBtn) begin
            stateQ <= PRESSED;
            countQ <= '0;
          end else if (countQ == CntLast) begin
            stateQ   <= IDLE;
            countQ   <= '0;
            levelQ   <= 1'b0;
            releaseQ <= 1'b1;
          end else begin
            countQ <= countQ + 1'b1;
          end
        end
        default: begin
          stateQ <= IDLE;
          countQ <= '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  logic enterPressed;
  logic enterIdle;
  logic holdActive;

  // Timer events coincide with the FSM edges that enter PRESSED / IDLE.
  assign enterPressed = (stateQ == PRESS_WAIT) && !btn.iIntBtn && (countQ == CntLast);
  assign enterIdle    = (stateQ == RELEASE_WAIT) && btn.iIntBtn && (countQ == CntLast);
  assign holdActive   = (stateQ == PRESSED);

  btn_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) uRepeatTimer (
    .CLK        (CLK),
    .RESET      (RESET),
    .iEnable    (holdActive),
    .iLoad      (enterPressed),
    .iClear     (enterIdle),
    .oBtnRepeat (repeatPulse)
  );
`else
  assign repeatPulse = 1'b0;
`endif

  assign btn.oBtnLevel   = levelQ;
  assign btn.oBtnPress   = pressQ;
  assign btn.oBtnRelease = releaseQ;
  assign btn.oBtnRepeat  = repeatPulse;

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3). Expectations follow BTN_AUTOREPEAT_EN.
module tb_button_debounce;

  localparam int unsigned Dbc = 4;
  localparam int unsigned Dly = 10;
  localparam int unsigned Per = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RepeatOn = 1'b1;
`else
  localparam bit RepeatOn = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  button_debounce_if btnBus ();

  button_debounce #(
    .DEBOUNCE_CYCLES (Dbc),
    .REPEAT_DELAY    (Dly),
    .REPEAT_PERIOD   (Per)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (btnBus)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOut(input string tag, input logic lvl, input logic prs,
                          input logic rel, input logic rpt);
    checkVal({tag, ".level"},   btnBus.oBtnLevel,   lvl);
    checkVal({tag, ".press"},   btnBus.oBtnPress,   prs);
    checkVal({tag, ".release"}, btnBus.oBtnRelease, rel);
    checkVal({tag, ".repeat"},  btnBus.oBtnRepeat,  rpt);
  endtask

  // Drive the button, let one rising edge sample it, then observe 1 ns later.
  task automatic cycle(input logic b);
    btnBus.iIntBtn = b;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    btnBus.iIntBtn = 1'b1;

    // Reset with button released.
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1);
    checkOut("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    cycle(1'b1);
    checkOut("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Short low glitch (3 samples) must be rejected.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checkOut("shortlow", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1);
    checkOut("shortlow.back", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);

    // Press: strobe only after the 4th low sample.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checkOut("presswait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0);
    checkOut("press", 1'b1, 1'b1, 1'b0, 1'b0);

    // Hold 20 cycles: repeats at press+10, +13, +16, +19 when enabled.
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0);
      checkOut($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b0,
               RepeatOn && (k == 10 || k == 13 || k == 16 || k == 19));
    end

    // Two-sample high glitch while pressed: no release, timer pauses.
    cycle(1'b1);
    checkOut("glitch1", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    checkOut("glitch2", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0);
    checkOut("glitch.back", 1'b1, 1'b0, 1'b0, 1'b0);

    // Real release; the first high sample is still a held cycle for the timer.
    cycle(1'b1);
    checkOut("relwait1", 1'b1, 1'b0, 1'b0, RepeatOn);
    cycle(1'b1);
    checkOut("relwait2", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    checkOut("relwait3", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    checkOut("release", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1);
    checkOut("released", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during PRESS_WAIT (count=2) discards progress.
    cycle(1'b0);
    cycle(1'b0);
    RESET = 1'b1;
    cycle(1'b0);
    checkOut("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checkOut("postreset.wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0);
    checkOut("postreset.press", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0);
    checkOut("postreset.held", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
